// File: rtl/blink_pkg.sv
`default_nettype none
// ============================================================================
// Module  : blink_pkg
// Brief   : Shared types and default timing for the LED blink generator and
//           the LED blink monitor.
// Revision: 1.0 - initial release
// ============================================================================
package blink_pkg;

  // Monitor tracking states
  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    MEAS   = 2'd1,
    LOCKED = 2'd2,
    STUCK  = 2'd3
  } state_e;

  // Default blink timing. The generator toggles its output every
  // c_def_num_count cycles, so its count equals the monitor's half-period.
  localparam int c_def_half_period = 5;
  localparam int c_def_num_count   = c_def_half_period;
  localparam int c_def_tol         = 1;
  localparam int c_def_lock_n      = 4;
  localparam int c_def_timeout     = 20;
  localparam int c_def_cnt_w       = 16;

endpackage : blink_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module  : sync_edge_det
// Brief   : Two-flop synchronizer for an asynchronous level, followed by a
//           registered any-polarity edge pulse.
// Revision: 1.0 - initial release
// ============================================================================
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic lvl_o,
  output logic edge_o
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_edge;

  // Synchronize d_i, remember the previous synchronized level, register the change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= d_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_edge  <= r_sync2 ^ r_prev;
    end
  end

  assign lvl_o  = r_sync2;
  assign edge_o = r_edge;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/led_blink_monitor.sv
`default_nettype none
// ============================================================================
// Module  : led_blink_monitor
// Brief   : Receive-side checker for the LED blink line. Measures the cycles
//           between toggles, flags out-of-tolerance intervals, declares lock
//           after a run of good intervals and detects a stuck line.
// Revision: 1.0 - initial release
// ============================================================================
module led_blink_monitor
  import blink_pkg::*;
#(
  parameter int HALF_PERIOD = c_def_half_period,
  parameter int TOL         = c_def_tol,
  parameter int LOCK_N      = c_def_lock_n,
  parameter int TIMEOUT     = c_def_timeout,
  parameter int CNT_W       = c_def_cnt_w
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             led_i,
  input  logic             en_i,
  output logic             locked_o,
  output logic             err_o,
  output logic             stuck_o,
  output logic [CNT_W-1:0] period_o,
  output logic [15:0]      edge_cnt_o
);

  // Refuse to build with a tolerance window or timeout that cannot work
  if (TOL >= HALF_PERIOD) begin : g_chk_tol
    $error("led_blink_monitor: TOL must be smaller than HALF_PERIOD");
  end
  if (TIMEOUT <= HALF_PERIOD + TOL) begin : g_chk_timeout
    $error("led_blink_monitor: TIMEOUT must exceed HALF_PERIOD+TOL");
  end
  if (CNT_W < 32 && longint'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_chk_cnt_w
    $error("led_blink_monitor: CNT_W too narrow to hold TIMEOUT");
  end

  localparam int               c_gr_w    = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] c_lo      = CNT_W'(HALF_PERIOD - TOL);
  localparam logic [CNT_W-1:0] c_hi      = CNT_W'(HALF_PERIOD + TOL);
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
  localparam logic [c_gr_w-1:0] c_last_gr = c_gr_w'(LOCK_N - 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_iv_cnt;
  logic [c_gr_w-1:0]  r_good_run;
  logic [CNT_W-1:0]   r_period;
  logic [15:0]        r_edge_cnt;
  logic               r_locked;
  logic               r_err;
  logic               r_stuck;

  logic w_edge;
  logic w_lvl_unused;  // synchronized level is not needed by the monitor
  logic w_good;
  logic w_timeout;

  sync_edge_det u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (led_i),
    .lvl_o  (w_lvl_unused),
    .edge_o (w_edge)
  );

  // The interval being closed by an edge is the current counter value
  assign w_good    = (r_iv_cnt >= c_lo) && (r_iv_cnt <= c_hi);
  assign w_timeout = (r_iv_cnt == c_timeout);

  // Interval counter, edge counter and tracking FSM with registered state decodes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= SEEK;
      r_iv_cnt   <= '0;
      r_good_run <= '0;
      r_period   <= '0;
      r_edge_cnt <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_stuck    <= 1'b0;
    end else if (!en_i) begin
      // Disabled: forget all tracking, keep the last reported period
      r_state    <= SEEK;
      r_iv_cnt   <= '0;
      r_good_run <= '0;
      r_edge_cnt <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_stuck    <= 1'b0;
    end else begin
      r_err <= 1'b0;

      if (w_edge) begin
        r_iv_cnt   <= CNT_W'(1);
        r_edge_cnt <= r_edge_cnt + 16'd1;
      end else if (!w_timeout) begin
        r_iv_cnt <= r_iv_cnt + CNT_W'(1);
      end

      unique case (r_state)
        SEEK: begin
          // First edge only opens an interval; nothing to measure yet
          if (w_edge) begin
            r_state    <= MEAS;
            r_good_run <= '0;
          end
        end

        MEAS: begin
          if (w_edge) begin
            r_period <= r_iv_cnt;
            if (w_good) begin
              r_good_run <= r_good_run + c_gr_w'(1);
              if (r_good_run == c_last_gr) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_err      <= 1'b1;
              r_good_run <= '0;
            end
          end else if (w_timeout) begin
            r_state    <= STUCK;
            r_stuck    <= 1'b1;
            r_good_run <= '0;
          end
        end

        LOCKED: begin
          if (w_edge) begin
            r_period <= r_iv_cnt;
            if (!w_good) begin
              r_err      <= 1'b1;
              r_state    <= MEAS;
              r_locked   <= 1'b0;
              r_good_run <= '0;
            end
          end else if (w_timeout) begin
            r_state    <= STUCK;
            r_locked   <= 1'b0;
            r_stuck    <= 1'b1;
            r_good_run <= '0;
          end
        end

        STUCK: begin
          // The line moved again: restart measuring without blaming the gap
          if (w_edge) begin
            r_state <= MEAS;
            r_stuck <= 1'b0;
          end
        end

        default: r_state <= SEEK;
      endcase
    end
  end

  assign locked_o   = r_locked;
  assign err_o      = r_err;
  assign stuck_o    = r_stuck;
  assign period_o   = r_period;
  assign edge_cnt_o = r_edge_cnt;

endmodule : led_blink_monitor
`default_nettype wire

// File: tb/tb_led_blink_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_blink_monitor
// Brief   : Directed self-checking bench for led_blink_monitor with default
//           timing (half-period 5, tolerance 1, lock after 4, timeout 20).
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_blink_monitor;

  logic        clk;
  logic        rst;
  logic        led_i;
  logic        en_i;
  logic        locked_o;
  logic        err_o;
  logic        stuck_o;
  logic [15:0] period_o;
  logic [15:0] edge_cnt_o;

  int checks;
  int errors;
  int err_pulses;
  int err_snap;

  led_blink_monitor #(
    .HALF_PERIOD (5),
    .TOL         (1),
    .LOCK_N      (4),
    .TIMEOUT     (20),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .led_i      (led_i),
    .en_i       (en_i),
    .locked_o   (locked_o),
    .err_o      (err_o),
    .stuck_o    (stuck_o),
    .period_o   (period_o),
    .edge_cnt_o (edge_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every err_o pulse, sampled mid-cycle
  initial err_pulses = 0;
  always @(negedge clk) if (err_o === 1'b1) err_pulses = err_pulses + 1;

  // Advance n clocks; inputs are driven and outputs read 1 time unit after posedge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Toggle led_i and then wait n cycles, so consecutive toggles are n apart
  task automatic toggle_wait(input int n);
    led_i = ~led_i;
    tick(n);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    en_i   = 1'b1;
    led_i  = 1'b0;

    // ---- 1. reset hold with a busy line, then a quiet line ----
    tick(1);
    led_i = 1'b1; tick(1);
    led_i = 1'b0; tick(1);
    led_i = 1'b1; tick(1);
    check("rst_locked", {31'd0, locked_o}, 32'd0);
    check("rst_err",    {31'd0, err_o},    32'd0);
    check("rst_stuck",  {31'd0, stuck_o},  32'd0);
    check("rst_period", {16'd0, period_o}, 32'd0);
    check("rst_edges",  {16'd0, edge_cnt_o}, 32'd0);
    led_i = 1'b0;
    rst   = 1'b0;
    err_snap = err_pulses;
    tick(30);
    check("quiet_edges",  {16'd0, edge_cnt_o}, 32'd0);
    check("quiet_stuck",  {31'd0, stuck_o},    32'd0);
    check("quiet_locked", {31'd0, locked_o},   32'd0);
    check("quiet_err",    err_pulses - err_snap, 32'd0);

    // ---- 2. clean lock at interval 5 ----
    err_snap = err_pulses;
    for (int k = 0; k < 4; k++) toggle_wait(5);
    toggle_wait(3);
    check("lock_early", {31'd0, locked_o}, 32'd0);
    tick(1);
    check("lock_rise",   {31'd0, locked_o},   32'd1);
    check("lock_period", {16'd0, period_o},   32'd5);
    check("lock_edges",  {16'd0, edge_cnt_o}, 32'd5);
    tick(1);
    check("lock_noerr",  err_pulses - err_snap, 32'd0);

    // ---- 3. jitter inside tolerance, then one bad interval and relock ----
    err_snap = err_pulses;
    toggle_wait(4);   // interval 5
    toggle_wait(6);   // interval 4
    toggle_wait(5);   // interval 6
    toggle_wait(7);   // interval 5
    check("jit_locked", {31'd0, locked_o}, 32'd1);
    check("jit_period", {16'd0, period_o}, 32'd5);
    check("jit_noerr",  err_pulses - err_snap, 32'd0);
    toggle_wait(3);   // interval 7
    check("bad_pre_locked", {31'd0, locked_o}, 32'd1);
    tick(1);
    check("bad_err",    {31'd0, err_o},    32'd1);
    check("bad_locked", {31'd0, locked_o}, 32'd0);
    check("bad_period", {16'd0, period_o}, 32'd7);
    tick(1);
    check("bad_err_end", {31'd0, err_o}, 32'd0);
    toggle_wait(5);
    toggle_wait(5);
    toggle_wait(5);
    toggle_wait(3);
    check("relock_early", {31'd0, locked_o}, 32'd0);
    tick(1);
    check("relock_rise", {31'd0, locked_o}, 32'd1);
    tick(1);
    check("bad_one_err", err_pulses - err_snap, 32'd1);

    // ---- 4. stuck line ----
    err_snap = err_pulses;
    tick(18);         // 23 cycles after the last toggle
    check("stuck_early",  {31'd0, stuck_o},  32'd0);
    check("stuck_locked", {31'd0, locked_o}, 32'd1);
    tick(1);
    check("stuck_rise",   {31'd0, stuck_o},  32'd1);
    check("stuck_unlock", {31'd0, locked_o}, 32'd0);
    tick(6);
    check("stuck_hold",   {31'd0, stuck_o},  32'd1);
    toggle_wait(3);
    check("stuck_pre_clear", {31'd0, stuck_o}, 32'd1);
    tick(1);
    check("stuck_clear",  {31'd0, stuck_o},  32'd0);
    check("stuck_noerr",  err_pulses - err_snap, 32'd0);
    check("stuck_period", {16'd0, period_o}, 32'd5);
    tick(1);
    // back in MEAS: four good intervals relock
    toggle_wait(5);
    toggle_wait(5);
    toggle_wait(5);
    toggle_wait(3);
    check("unstuck_early", {31'd0, locked_o}, 32'd0);
    tick(1);
    check("unstuck_lock",  {31'd0, locked_o},   32'd1);
    check("unstuck_edges", {16'd0, edge_cnt_o}, 32'd19);
    tick(1);

    // ---- 5. enable drop while locked ----
    en_i = 1'b0;
    tick(1);
    en_i = 1'b1;
    check("en_locked", {31'd0, locked_o},   32'd0);
    check("en_edges",  {16'd0, edge_cnt_o}, 32'd0);
    check("en_period", {16'd0, period_o},   32'd5);
    check("en_stuck",  {31'd0, stuck_o},    32'd0);
    for (int k = 0; k < 4; k++) toggle_wait(5);
    toggle_wait(3);
    check("en_relock_early", {31'd0, locked_o}, 32'd0);
    tick(1);
    check("en_relock",       {31'd0, locked_o},   32'd1);
    check("en_relock_edges", {16'd0, edge_cnt_o}, 32'd5);
    tick(1);

    // ---- 6. reset in the middle of MEAS ----
    toggle_wait(8);   // interval 5, still locked
    toggle_wait(4);   // interval 8: back to MEAS
    check("meas_err",    {31'd0, err_o},    32'd1);
    check("meas_locked", {31'd0, locked_o}, 32'd0);
    check("meas_period", {16'd0, period_o}, 32'd8);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mrst_locked", {31'd0, locked_o},   32'd0);
    check("mrst_err",    {31'd0, err_o},      32'd0);
    check("mrst_stuck",  {31'd0, stuck_o},    32'd0);
    check("mrst_period", {16'd0, period_o},   32'd0);
    check("mrst_edges",  {16'd0, edge_cnt_o}, 32'd0);
    for (int k = 0; k < 4; k++) toggle_wait(5);
    toggle_wait(3);
    check("mrst_lock_early", {31'd0, locked_o}, 32'd0);
    tick(1);
    check("mrst_lock",   {31'd0, locked_o},   32'd1);
    check("mrst_edges5", {16'd0, edge_cnt_o}, 32'd5);
    check("mrst_period5", {16'd0, period_o},  32'd5);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_led_blink_monitor
`default_nettype wire
